// File: rtl/tm1638_responder_pkg.sv
// Shared types and helpers for the TM1638 device-side responder.
package tm1638_responder_pkg;
  `include "tm1638_defs.vh"

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  localparam logic [2:0] KEY_BYTES = 3'd4;

  // Key scan byte n carries two switches: bit0 from the upper half, bit4 from the lower half.
  function automatic logic [7:0] key_byte(input logic [7:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = {3'b000, snap[3], 3'b000, snap[7]};
      3'd1:    b = {3'b000, snap[2], 3'b000, snap[6]};
      3'd2:    b = {3'b000, snap[1], 3'b000, snap[5]};
      3'd3:    b = {3'b000, snap[0], 3'b000, snap[4]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction
endpackage

// File: rtl/sync_bit.sv
// Plain flop-chain synchronizer for one asynchronous input pin.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/tm1638_defs.vh
// Command-field constants shared by the TM1638 host-side controller and the
// device-side responder.
`ifndef TM1638_DEFS_VH
`define TM1638_DEFS_VH
localparam logic [1:0] C_DATA    = 2'b01;
localparam logic [1:0] C_DISP    = 2'b10;
localparam logic [1:0] C_ADDR    = 2'b11;
localparam int         READ_BIT  = 1;
localparam int         FIXED_BIT = 2;
`endif

// File: rtl/tm1638_responder.sv
// TM1638-compatible serial responder: decodes host frames into display RAM,
// display control and key-scan read-back.
module tm1638_responder
  import tm1638_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tm_stb,
  input  logic       tm_clk,
  input  logic       tm_dio_in,
  output logic       tm_dio_out,
  output logic       tm_dio_oe,
  input  logic [7:0] keys,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic [7:0] digit3,
  output logic [7:0] digit4,
  output logic [7:0] digit5,
  output logic [7:0] digit6,
  output logic [7:0] digit7,
  output logic [7:0] digit8,
  output logic [7:0] leds,
  output logic       display_on,
  output logic [2:0] brightness,
  output logic       frame_err
);
  logic       stb_s, sclk_s, dio_s;
  logic       stb_q, sclk_q;
  logic       stb_rise, stb_fall, stb_edge;
  logic       clk_rise, clk_fall;
  logic       bit_tick, byte_done, rd_start;
  logic [7:0] rx_byte;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] ram [16];
  logic [3:0] addr;
  logic       read_mode, fixed_mode;
  logic [7:0] keys_snap;
  logic [2:0] rd_bit, rd_idx;
  logic [7:0] cur_key;
  state_t     state, state_next;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_stb (.clk(clk), .d(tm_stb),    .q(stb_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk(clk), .d(tm_clk),    .q(sclk_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dio (.clk(clk), .d(tm_dio_in), .q(dio_s));

  // Edge history is left unreset so a strobe held low across rst does not fake a new frame.
  always_ff @(posedge clk) begin
    stb_q  <= stb_s;
    sclk_q <= sclk_s;
  end

  assign stb_rise  = stb_s & ~stb_q;
  assign stb_fall  = ~stb_s & stb_q;
  assign stb_edge  = stb_rise | stb_fall;
  assign clk_rise  = sclk_s & ~sclk_q & ~stb_edge;
  assign clk_fall  = ~sclk_s & sclk_q & ~stb_edge;
  assign bit_tick  = clk_rise & (state != S_IDLE);
  assign byte_done = bit_tick & (bit_cnt == 3'd7);
  assign rx_byte   = {dio_s, shreg};
  assign rd_start  = byte_done & (state == S_CMD) & (rx_byte[7:6] == C_DATA) & rx_byte[READ_BIT];
  assign cur_key   = key_byte(keys_snap, rd_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stb_rise) begin
      state_next = S_IDLE;
    end else if (stb_fall) begin
      state_next = S_CMD;
    end else if (byte_done && state == S_CMD) begin
      state_next = S_IGNORE;
      if (rx_byte[7:6] == C_ADDR && !read_mode) state_next = S_WDATA;
      else if (rd_start)                        state_next = S_RDATA;
    end
  end

  always_ff @(posedge clk) begin
    frame_err <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      shreg      <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      read_mode  <= 1'b0;
      fixed_mode <= 1'b0;
      display_on <= 1'b0;
      brightness <= '0;
    end else begin
      if (stb_rise) begin
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
        bit_cnt <= '0;
      end else if (stb_fall) begin
        bit_cnt <= '0;
      end else if (bit_tick) begin
        shreg   <= rx_byte[7:1];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done && state == S_CMD) begin
        case (rx_byte[7:6])
          C_DATA: begin
            read_mode  <= rx_byte[READ_BIT];
            fixed_mode <= rx_byte[FIXED_BIT];
          end
          C_ADDR: addr <= rx_byte[3:0];
          C_DISP: begin
            display_on <= rx_byte[3];
            brightness <= rx_byte[2:0];
          end
          default: ;
        endcase
      end else if (byte_done && state == S_WDATA) begin
        ram[addr] <= rx_byte;
        if (!fixed_mode) addr <= addr + 4'd1;
      end
    end
  end

  // The pad is only driven while a read frame is open; bits advance on the host's falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tm_dio_oe  <= 1'b0;
      tm_dio_out <= 1'b1;
      keys_snap  <= '0;
      rd_bit     <= '0;
      rd_idx     <= '0;
    end else if (state != S_RDATA || stb_rise) begin
      tm_dio_oe  <= 1'b0;
      tm_dio_out <= 1'b1;
      if (rd_start) begin
        keys_snap <= keys;
        rd_bit    <= '0;
        rd_idx    <= '0;
      end
    end else if (clk_fall) begin
      tm_dio_oe  <= 1'b1;
      tm_dio_out <= cur_key[rd_bit];
      rd_bit     <= rd_bit + 3'd1;
      if (rd_bit == 3'd7 && rd_idx < KEY_BYTES) rd_idx <= rd_idx + 3'd1;
    end
  end

  assign digit1 = ram[0];
  assign digit2 = ram[2];
  assign digit3 = ram[4];
  assign digit4 = ram[6];
  assign digit5 = ram[8];
  assign digit6 = ram[10];
  assign digit7 = ram[12];
  assign digit8 = ram[14];

  always_comb begin
    leds = '0;
    for (int i = 0; i < 8; i++) leds[7-i] = ram[2*i+1][0];
  end
endmodule

// File: tb/tb_tm1638_responder.sv
// Directed testbench for tm1638_responder with a frame-level behavioural model
// compared against the DUT whenever the bus is quiet.
module tb_tm1638_responder;
  localparam int HALF = 8;
  localparam logic [78:0] RESET_VEC = 79'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tm_stb, tm_clk, tm_dio_in;
  logic       tm_dio_out, tm_dio_oe;
  logic [7:0] keys;
  logic [7:0] digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;
  logic [7:0] leds;
  logic       display_on;
  logic [2:0] brightness;
  logic       frame_err;

  int checks = 0;
  int passes = 0;
  int err_pulses = 0;
  int err_before;
  logic model_valid = 1'b0;

  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  logic       m_read, m_fixed, m_disp;
  logic [2:0] m_bright;
  logic [7:0] rd_log [5];

  wire [78:0] dut_vec = {digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8,
                         leds, display_on, brightness, tm_dio_oe, tm_dio_out, frame_err};

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio_in(tm_dio_in),
    .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe), .keys(keys),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .digit5(digit5), .digit6(digit6), .digit7(digit7), .digit8(digit8),
    .leds(leds), .display_on(display_on), .brightness(brightness), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Expected quiet-bus outputs: even RAM bytes are digits, odd RAM bit0 are LEDs from addr 1 downward.
  function automatic logic [78:0] model_vec();
    logic [63:0] d;
    logic [7:0]  l;
    for (int i = 0; i < 8; i++) begin
      d[63-8*i -: 8] = m_ram[2*i];
      l[7-i]         = m_ram[2*i+1][0];
    end
    return {d, l, m_disp, m_bright, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr = 0; m_read = 0; m_fixed = 0; m_disp = 0; m_bright = 0;
  endtask

  task automatic model_frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    case (b0[7:6])
      2'b01: begin m_read = b0[1]; m_fixed = b0[2]; end
      2'b10: begin m_disp = b0[3]; m_bright = b0[2:0]; end
      2'b11: begin
        m_addr = b0[3:0];
        if (!m_read) begin
          for (int k = 1; k < n; k++) begin
            m_ram[m_addr] = bs[k];
            if (!m_fixed) m_addr = m_addr + 4'd1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_output(input string name, input logic [78:0] actual, input logic [78:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (model_valid) check_output("quiet_outputs", dut_vec, model_vec());
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tm_clk = 1'b0; tm_dio_in = b; tick(HALF);
    tm_clk = 1'b1; tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic frame_begin();
    model_valid = 1'b0;
    tm_stb = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    tm_stb = 1'b1; tm_dio_in = 1'b1;
    tick(HALF);
  endtask

  task automatic settle_check();
    model_valid = 1'b1;
    tick(4);
    model_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    frame_begin();
    send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    frame_end();
    model_frame(n, b0, b1, b2);
    settle_check();
  endtask

  task automatic read_frame(input int nbytes);
    logic [7:0] got, expb;
    logic       oe_all;
    frame_begin();
    send_byte(8'h42);
    m_read = 1'b1; m_fixed = 1'b0;
    tm_dio_in = 1'b1;
    for (int n = 0; n < nbytes; n++) begin
      got = 8'h00; oe_all = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tm_clk = 1'b0; tick(HALF);
        got[i] = tm_dio_out;
        oe_all = oe_all & tm_dio_oe;
        tm_clk = 1'b1; tick(HALF);
      end
      expb = 8'h00;
      if (n < 4) begin
        expb[0] = keys[7-n];
        expb[4] = keys[3-n];
      end
      check_output($sformatf("read_byte%0d", n), {71'd0, got}, {71'd0, expb});
      check_output($sformatf("read_oe%0d", n), {78'd0, oe_all}, 79'd1);
      rd_log[n] = got;
    end
    tm_stb = 1'b1;
    tick(4);
    check_output("oe_after_stb_rise", {78'd0, tm_dio_oe}, 79'd0);
    tick(HALF - 4);
    settle_check();
  endtask

  initial begin
    rst = 1'b1; tm_stb = 1'b1; tm_clk = 1'b1; tm_dio_in = 1'b1; keys = 8'h00;
    model_reset();
    tick(6);
    check_output("reset_state", dut_vec, RESET_VEC);
    rst = 1'b0;
    tick(4);
    settle_check();

    // Auto-increment write from address 0
    apply_stimulus(1, 8'h40, 8'h00, 8'h00);
    apply_stimulus(3, 8'hC0, 8'h3F, 8'h01);
    check_output("lit_digit1_3f", {71'd0, digit1}, 79'h3F);
    check_output("lit_leds_80", {71'd0, leds}, 79'h80);

    // Fixed-address mode overwrites the same location
    apply_stimulus(1, 8'h44, 8'h00, 8'h00);
    apply_stimulus(3, 8'hC5, 8'hAA, 8'h55);
    check_output("lit_leds_a0", {71'd0, leds}, 79'hA0);
    check_output("lit_digit3_00", {71'd0, digit3}, 79'h00);

    // Auto-increment wraps from 15 to 0
    apply_stimulus(1, 8'h40, 8'h00, 8'h00);
    apply_stimulus(3, 8'hCF, 8'h11, 8'h22);
    check_output("lit_digit1_22", {71'd0, digit1}, 79'h22);
    check_output("lit_leds_a1", {71'd0, leds}, 79'hA1);

    keys = 8'h81;
    read_frame(5);
    check_output("lit_rd0", {71'd0, rd_log[0]}, 79'h01);
    check_output("lit_rd1", {71'd0, rd_log[1]}, 79'h00);
    check_output("lit_rd3", {71'd0, rd_log[3]}, 79'h10);
    check_output("lit_rd4", {71'd0, rd_log[4]}, 79'h00);

    // Display control; trailing byte in the same frame is ignored
    apply_stimulus(2, 8'h8B, 8'hC3, 8'h00);
    check_output("lit_display_on", {78'd0, display_on}, 79'd1);
    check_output("lit_brightness", {76'd0, brightness}, 79'd3);

    apply_stimulus(1, 8'h40, 8'h00, 8'h00);
    err_before = err_pulses;
    frame_begin();
    send_byte(8'hC0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_end();
    model_frame(1, 8'hC0, 8'h00, 8'h00);
    settle_check();
    check_output("frame_err_once", 79'(err_pulses - err_before), 79'd1);

    // Reset lands in the middle of a data byte
    err_before = err_pulses;
    frame_begin();
    send_byte(8'hC0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    tick(3);
    check_output("reset_mid_frame", dut_vec, RESET_VEC);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    frame_end();
    settle_check();
    check_output("no_err_after_reset", 79'(err_pulses - err_before), 79'd0);
    apply_stimulus(1, 8'h40, 8'h00, 8'h00);
    apply_stimulus(2, 8'hC2, 8'h5B, 8'h00);
    check_output("lit_digit2_5b", {71'd0, digit2}, 79'h5B);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
